// File: rtl/cook_pkg.sv
// Shared types and constants for the microwave cook sequencer:
// state encodings, the MM:SS time record and the BCD countdown helper.
package cook_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SET    = 3'd1,
        ST_COOK   = 3'd2,
        ST_PAUSED = 3'd3,
        ST_DONE   = 3'd4
    } cook_state_t;

    // Largest value of a units digit and of a seconds-tens digit after a borrow
    localparam logic [3:0] BCD_UNITS_MAX = 4'd9;
    localparam logic [3:0] BCD_TENS_MAX  = 4'd5;

    // Remaining time, minutes tens in the top nibble down to seconds ones
    typedef struct packed {
        logic [3:0] mt;
        logic [3:0] mo;
        logic [3:0] st;
        logic [3:0] so;
    } cook_time_t;

    // One-second decrement with borrow; seconds fields above 59 are not
    // normalised, they simply count down digit by digit.
    function automatic cook_time_t time_dec(input cook_time_t t);
        cook_time_t r;
        r = t;
        if (t.so != 4'd0) begin
            r.so = t.so - 4'd1;
        end else if (t.st != 4'd0) begin
            r.st = t.st - 4'd1;
            r.so = BCD_UNITS_MAX;
        end else if (t.mo != 4'd0) begin
            r.mo = t.mo - 4'd1;
            r.st = BCD_TENS_MAX;
            r.so = BCD_UNITS_MAX;
        end else if (t.mt != 4'd0) begin
            r.mt = t.mt - 4'd1;
            r.mo = BCD_UNITS_MAX;
            r.st = BCD_TENS_MAX;
            r.so = BCD_UNITS_MAX;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_countdown.sv
// Four-digit MM:SS store: keypad shift-in, one-second decrement and clear.
// Also reports whether the time is zero now and whether it would be zero
// after a decrement, so the controller can finish on the last tick.
module bcd_countdown
    import cook_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       clear,
    input  logic       shift,
    input  logic [3:0] shift_digit,
    input  logic       dec,
    output cook_time_t time_val,
    output logic       zero,
    output logic       dec_zero
);

    cook_time_t time_reg;
    cook_time_t time_next;
    cook_time_t dec_val;

    assign dec_val  = time_dec(time_reg);
    assign time_val = time_reg;
    assign zero     = (time_reg == '0);
    assign dec_zero = (dec_val == '0);

    // Select the next time value; clear dominates keypad entry, which dominates the tick
    always_comb begin
        time_next = time_reg;
        if (clear) begin
            time_next = '0;
        end else if (shift) begin
            time_next = {time_reg.mo, time_reg.st, time_reg.so, shift_digit};
        end else if (dec) begin
            time_next = dec_val;
        end
    end

    // Digit storage, cleared asynchronously on reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            time_reg <= '0;
        end else begin
            time_reg <= time_next;
        end
    end

endmodule

// File: rtl/cook_sequencer.sv
// Microwave cook controller: keypad time entry, start/pause/clear control,
// one-second prescaler and magnetron enable.
module cook_sequencer
    import cook_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       startn,
    input  logic       stopn,
    input  logic       clearn,
    input  logic       door_closed,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    output logic       mag_on,
    output logic       timer_done,
    output logic [3:0] disp_mt,
    output logic [3:0] disp_mo,
    output logic [3:0] disp_st,
    output logic [3:0] disp_so,
    output logic [2:0] state
);

    localparam int unsigned PRE_W = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    cook_state_t      state_reg;
    logic [PRE_W-1:0] prescale_reg;
    cook_time_t       time_val;
    logic             time_zero;
    logic             dec_zero;
    logic             tick;
    logic             key_ok;
    logic             start_ok;
    logic             clr_time;
    logic             shift_time;
    logic             dec_time;

    assign tick   = (state_reg == ST_COOK) && (prescale_reg == PRE_LAST);
    assign key_ok = key_valid && (key_digit <= BCD_UNITS_MAX);

    // Start only counts when no higher-priority event is active and there is time left
    assign start_ok = door_closed && stopn && !startn && !time_zero;

    // Datapath strobes derived from the current state and prioritised events
    always_comb begin
        clr_time   = 1'b0;
        shift_time = 1'b0;
        dec_time   = 1'b0;
        if (!clearn) begin
            clr_time = 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE, ST_SET: shift_time = door_closed && stopn && startn && key_ok;
                ST_COOK:         dec_time   = tick;
                ST_DONE:         clr_time   = !door_closed || !stopn;
                default:         ;
            endcase
        end
    end

    // Controller state and prescaler; prescaler only advances while cooking
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= ST_IDLE;
            prescale_reg <= '0;
        end else begin
            prescale_reg <= '0;
            if (!clearn) begin
                state_reg <= ST_IDLE;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (shift_time) state_reg <= ST_SET;
                    end
                    ST_SET: begin
                        if (start_ok) state_reg <= ST_COOK;
                    end
                    ST_COOK: begin
                        prescale_reg <= tick ? '0 : prescale_reg + PRE_W'(1);
                        // The last tick wins over a simultaneous pause request
                        if (tick && dec_zero) begin
                            state_reg <= ST_DONE;
                        end else if (!door_closed || !stopn) begin
                            state_reg    <= ST_PAUSED;
                            prescale_reg <= '0;
                        end
                    end
                    ST_PAUSED: begin
                        if (start_ok) state_reg <= ST_COOK;
                    end
                    ST_DONE: begin
                        if (!door_closed || !stopn) state_reg <= ST_IDLE;
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    bcd_countdown u_countdown (
        .clk         (clk),
        .resetn      (resetn),
        .clear       (clr_time),
        .shift       (shift_time),
        .shift_digit (key_digit),
        .dec         (dec_time),
        .time_val    (time_val),
        .zero        (time_zero),
        .dec_zero    (dec_zero)
    );

    // Door opening must cut the magnetron without waiting for a clock edge
    assign mag_on     = (state_reg == ST_COOK) && door_closed;
    assign timer_done = (state_reg == ST_DONE);
    assign state      = state_reg;
    assign disp_mt    = time_val.mt;
    assign disp_mo    = time_val.mo;
    assign disp_st    = time_val.st;
    assign disp_so    = time_val.so;

endmodule

// File: tb/tb_cook_sequencer.sv
// Directed bench for cook_sequencer with TICK_DIV=4.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_cook_sequencer;

    logic       clk;
    logic       resetn;
    logic       startn;
    logic       stopn;
    logic       clearn;
    logic       door_closed;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       mag_on;
    logic       timer_done;
    logic [3:0] disp_mt;
    logic [3:0] disp_mo;
    logic [3:0] disp_st;
    logic [3:0] disp_so;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SET    = 3'd1;
    localparam logic [2:0] S_COOK   = 3'd2;
    localparam logic [2:0] S_PAUSED = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    cook_sequencer #(.TICK_DIV(4)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .startn      (startn),
        .stopn       (stopn),
        .clearn      (clearn),
        .door_closed (door_closed),
        .key_valid   (key_valid),
        .key_digit   (key_digit),
        .mag_on      (mag_on),
        .timer_done  (timer_done),
        .disp_mt     (disp_mt),
        .disp_mo     (disp_mo),
        .disp_st     (disp_st),
        .disp_so     (disp_so),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic key(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        cyc(1);
        key_valid = 1'b0;
        $display("key %0d -> state=%0d disp=%0h%0h:%0h%0h", d, state, disp_mt, disp_mo, disp_st, disp_so);
    endtask

    task automatic start_pulse();
        startn = 1'b0;
        cyc(1);
        startn = 1'b1;
        $display("start -> state=%0d mag_on=%0b", state, mag_on);
    endtask

    task automatic clear_pulse();
        clearn = 1'b0;
        cyc(1);
        clearn = 1'b1;
        $display("clear -> state=%0d", state);
    endtask

    function automatic logic [15:0] disp();
        return {disp_mt, disp_mo, disp_st, disp_so};
    endfunction

    initial begin
        resetn      = 1'b0;
        startn      = 1'b1;
        stopn       = 1'b1;
        clearn      = 1'b1;
        door_closed = 1'b1;
        key_valid   = 1'b0;
        key_digit   = 4'd0;

        // Reset state
        cyc(2);
        chk("rst_state", 16'(state), 16'(S_IDLE));
        chk("rst_mag", 16'(mag_on), 16'd0);
        chk("rst_done", 16'(timer_done), 16'd0);
        chk("rst_disp", disp(), 16'h0000);
        #2 resetn = 1'b1;
        cyc(1);
        chk("post_rst_state", 16'(state), 16'(S_IDLE));

        // 00:12 full cook cycle
        key(4'd0);
        chk("k0_state", 16'(state), 16'(S_SET));
        key(4'd0);
        key(4'd1);
        key(4'd2);
        chk("k12_disp", disp(), 16'h0012);
        start_pulse();
        chk("c12_state", 16'(state), 16'(S_COOK));
        chk("c12_mag", 16'(mag_on), 16'd1);
        chk("c12_disp", disp(), 16'h0012);
        cyc(3);
        chk("c12_pre3", disp(), 16'h0012);
        cyc(1);
        chk("c12_tick1", disp(), 16'h0011);
        cyc(43);
        chk("c12_e47_disp", disp(), 16'h0001);
        chk("c12_e47_state", 16'(state), 16'(S_COOK));
        cyc(1);
        $display("cook end -> state=%0d disp=%0h mag_on=%0b", state, disp(), mag_on);
        chk("c12_end_disp", disp(), 16'h0000);
        chk("c12_end_done", 16'(timer_done), 16'd1);
        chk("c12_end_mag", 16'(mag_on), 16'd0);
        chk("c12_end_state", 16'(state), 16'(S_DONE));
        start_pulse();
        chk("done_start_ign", 16'(state), 16'(S_DONE));
        door_closed = 1'b0;
        cyc(1);
        door_closed = 1'b1;
        chk("done_door_idle", 16'(state), 16'(S_IDLE));
        chk("done_door_tdone", 16'(timer_done), 16'd0);

        // 01:00 borrow through minutes
        key(4'd1);
        key(4'd0);
        key(4'd0);
        chk("k100_disp", disp(), 16'h0100);
        start_pulse();
        cyc(4);
        chk("c100_tick1", disp(), 16'h0059);
        cyc(36);
        chk("c100_tick10", disp(), 16'h0050);
        clear_pulse();
        chk("c100_clr_state", 16'(state), 16'(S_IDLE));
        chk("c100_clr_disp", disp(), 16'h0000);
        chk("c100_clr_mag", 16'(mag_on), 16'd0);

        // 00:30 door open, resume, stop coincident with tick
        key(4'd3);
        key(4'd0);
        start_pulse();
        cyc(4);
        chk("c30_tick1", disp(), 16'h0029);
        cyc(2);
        door_closed = 1'b0;
        #1;
        chk("door_mag_comb", 16'(mag_on), 16'd0);
        chk("door_state_before", 16'(state), 16'(S_COOK));
        cyc(1);
        chk("door_paused", 16'(state), 16'(S_PAUSED));
        cyc(5);
        chk("door_hold_disp", disp(), 16'h0029);
        start_pulse();
        chk("door_open_start_ign", 16'(state), 16'(S_PAUSED));
        door_closed = 1'b1;
        start_pulse();
        chk("resume_state", 16'(state), 16'(S_COOK));
        chk("resume_disp", disp(), 16'h0029);
        chk("resume_mag", 16'(mag_on), 16'd1);
        cyc(3);
        stopn = 1'b0;
        cyc(1);
        stopn = 1'b1;
        chk("stop_tick_state", 16'(state), 16'(S_PAUSED));
        chk("stop_tick_disp", disp(), 16'h0028);
        clear_pulse();

        // Ignored starts and keys
        start_pulse();
        chk("zero_start_ign", 16'(state), 16'(S_IDLE));
        key(4'd12);
        chk("bad_key_state", 16'(state), 16'(S_IDLE));
        chk("bad_key_disp", disp(), 16'h0000);
        key(4'd7);
        chk("k7_disp", disp(), 16'h0007);
        key(4'd12);
        chk("bad_key_set", disp(), 16'h0007);
        start_pulse();
        key(4'd3);
        chk("cook_key_disp", disp(), 16'h0007);
        chk("cook_key_state", 16'(state), 16'(S_COOK));
        clear_pulse();

        // Clear beats start; asynchronous reset during cook
        key(4'd4);
        clearn = 1'b0;
        startn = 1'b0;
        cyc(1);
        clearn = 1'b1;
        startn = 1'b1;
        chk("clr_start_state", 16'(state), 16'(S_IDLE));
        chk("clr_start_disp", disp(), 16'h0000);
        key(4'd9);
        start_pulse();
        cyc(2);
        chk("pre_rst_mag", 16'(mag_on), 16'd1);
        resetn = 1'b0;
        #1;
        $display("async reset -> state=%0d mag_on=%0b", state, mag_on);
        chk("arst_mag", 16'(mag_on), 16'd0);
        chk("arst_state", 16'(state), 16'(S_IDLE));
        chk("arst_disp", disp(), 16'h0000);
        #2 resetn = 1'b1;
        cyc(1);
        chk("arst_release", 16'(state), 16'(S_IDLE));

        // Stop on the final tick finishes rather than pauses
        key(4'd5);
        start_pulse();
        cyc(19);
        chk("c5_e19_disp", disp(), 16'h0001);
        stopn = 1'b0;
        cyc(1);
        stopn = 1'b1;
        chk("c5_last_state", 16'(state), 16'(S_DONE));
        chk("c5_last_done", 16'(timer_done), 16'd1);
        chk("c5_last_disp", disp(), 16'h0000);
        key(4'd3);
        chk("done_key_ign", disp(), 16'h0000);
        chk("done_hold", 16'(state), 16'(S_DONE));
        stopn = 1'b0;
        cyc(1);
        stopn = 1'b1;
        chk("done_stop_idle", 16'(state), 16'(S_IDLE));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cook_sequencer.md
COOK_SEQUENCER -- requirements
Module: cook_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 100, meaning clk cycles per one-second countdown tick (range 2 to 2^24).
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 startn  input  1  start/resume request, active low, level-sampled.
REQ-005 stopn  input  1  pause request, active low, level-sampled.
REQ-006 clearn  input  1  abort and clear time, active low, level-sampled.
REQ-007 door_closed  input  1  1 = door closed.
REQ-008 key_valid  input  1  one-cycle strobe, key_digit is valid.
REQ-009 key_digit  input  4  BCD keypad digit.
REQ-010 mag_on  output  1  magnetron enable.
REQ-011 timer_done  output  1  cook cycle finished.
REQ-012 disp_mt, disp_mo, disp_st, disp_so  output  4 each  remaining time MM:SS, BCD.
REQ-013 state  output  3  current state encoding, for display and debug.

Function
REQ-014 States: IDLE=0, SET=1, COOK=2, PAUSED=3, DONE=4; codes 5-7 are illegal and SHALL go to IDLE on the next edge.
REQ-015 Event priority each cycle: clearn low > door_closed low > stopn low > startn low > key_valid.
REQ-016 clearn low in any state: next state IDLE, all four digits 0, prescaler 0.
REQ-017 IDLE/SET, key_valid=1, key_digit<=9: digits shift left (mt<=mo, mo<=st, st<=so, so<=key_digit), state SET.
REQ-018 key_digit>9, or key_valid=1 in COOK/PAUSED/DONE: key ignored, no change.
REQ-019 SET or PAUSED, startn low, door_closed high, time not 0000: go to COOK; otherwise startn is ignored.
REQ-020 startn low with time 0000: ignored, state unchanged.
REQ-021 COOK, door_closed low or stopn low: go to PAUSED, time held.
REQ-022 mag_on = (state==COOK) AND door_closed, combinational, so door opening drops mag_on in the same cycle.
REQ-023 Prescaler runs only in COOK and is cleared in every other state; the tick fires when it reaches TICK_DIV-1.
REQ-024 First tick after entering COOK fires exactly TICK_DIV cycles after entry.
REQ-025 Tick decrements time: so>0 gives so-1; else st>0 gives st-1, so=9; else mo>0 gives mo-1, st=5, so=9; else mt>0 gives mt-1, mo=9, st=5, so=9.
REQ-026 Seconds fields entered above 59 (e.g. 0090) are not normalised; they count down by REQ-025.
REQ-027 Tick that produces 0000 SHALL move COOK to DONE in the same edge, so mag_on drops with the last decrement.
REQ-028 timer_done = (state==DONE).
REQ-029 DONE: door_closed low or stopn low gives IDLE with digits 0; startn and keys ignored.
REQ-030 Simultaneous tick and stopn/door-open in COOK: the tick's decrement is applied and the state becomes PAUSED, or DONE if the result is 0000.

Reset
REQ-031 resetn low SHALL asynchronously force state IDLE, all digits 0, prescaler 0, mag_on 0, timer_done 0.
REQ-032 Reset mid-COOK SHALL drop mag_on immediately, without waiting for a clock edge.
REQ-033 Release of resetn is synchronous to clk; the first transition is evaluated on the first rising edge after release.

Structure
REQ-034 State encodings and the BCD limits (9, 5) SHALL live in shared package cook_pkg.
REQ-035 Digit storage and the decrement logic SHALL be sub-module bcd_countdown, with load/shift, dec, clear and zero outputs; the FSM and prescaler stay in cook_sequencer.

Verification (TICK_DIV=4)
REQ-036 Keys 0,0,1,2, then startn low for 1 cycle, door closed -> state COOK, mag_on=1, display 00:12; 4 cycles later 00:11; after 48 cycles 00:00, timer_done=1, mag_on=0.
REQ-037 Keys 1,0,0 (01:00), start, then 1 tick -> display 00:59; after 9 more ticks 00:50.
REQ-038 Cooking 00:30, door_closed low -> mag_on=0 in the same cycle; next state PAUSED, time held; door closed plus startn low -> COOK resumes from the held time.
REQ-039 Time 0000 plus startn low -> stays IDLE; key_digit=12 strobe -> digits unchanged; key during COOK -> ignored.
REQ-040 clearn and startn low together in SET -> IDLE with 00:00; resetn pulsed low during COOK -> mag_on=0 asynchronously, state IDLE.
REQ-041 Key 5 (00:05), start, stopn low on the cycle of the 5th tick -> state DONE, not PAUSED; timer_done=1.
